clock_set_ctrl: RTL and testbench
=================================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter LD_HOLD, default 16: clk cycles that LD_time, LD_alarm or STOP_al are held high; covers at least one divided 1 s clock period of the alarm clock.
REQ-002 Parameter TIMEOUT_S, default 10: tick_1s pulses with no accepted button event before an edit is abandoned.
REQ-003 Parameter SNOOZE_S, default 300: tick_1s pulses the buzzer stays muted after a snooze.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (low = reset).
REQ-006 btn_mode, btn_inc, btn_set  input  1 each  raw button levels, asynchronous to clk.
REQ-007 tick_1s  input  1  one-clk-cycle pulse, once per second.
REQ-008 alarm_in  input  1  Alarm output of the alarm clock.
REQ-009 H_in1 output 2, H_in0 output 4, M_in1 output 4, M_in0 output 4: BCD hour/minute of the edit registers, for the clock's load inputs.
REQ-010 LD_time, LD_alarm, STOP_al, AL_ON  output  1 each  control inputs of the alarm clock.
REQ-011 buzz  output  1  buzzer drive.
REQ-012 mode_ind  output  2  00 idle, 01 time edit, 10 alarm edit, 11 loading.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer; a rising edge of the synchronized level SHALL be one event, 1 cycle wide; simultaneous events SHALL resolve by priority set > mode > inc, and lower-priority events SHALL be dropped.
REQ-014 Edit registers: hour 0..23 and min 0..59 in binary; the BCD outputs SHALL be derived combinationally (tens = value/10, units = value mod 10).
REQ-015 States: IDLE, T_HOUR, T_MIN, T_LOAD, A_HOUR, A_MIN, A_LOAD, with these transitions:
  - IDLE: mode -> T_HOUR.
  - T_HOUR: mode -> A_HOUR; set -> T_MIN.
  - A_HOUR: mode -> IDLE; set -> A_MIN.
  - T_MIN: set -> T_LOAD.
  - A_MIN: set -> A_LOAD.
  - T_MIN, A_MIN: mode -> IDLE with no load.
REQ-016 inc in T_HOUR/A_HOUR SHALL increment hour, wrapping 23 -> 0; inc in T_MIN/A_MIN SHALL increment min, wrapping 59 -> 0.
REQ-017 T_LOAD SHALL drive LD_time high for exactly LD_HOLD cycles, then go to IDLE; A_LOAD SHALL do the same with LD_alarm; LD_time and LD_alarm SHALL never be high together.
REQ-018 The edit registers SHALL be stable during T_LOAD/A_LOAD, and all button events in those states SHALL be ignored.
REQ-019 In edit states, the timeout counter SHALL clear on entry and on every accepted event and count tick_1s; on reaching TIMEOUT_S the FSM SHALL return to IDLE with no load pulse.
REQ-020 IDLE, alarm_in=0: inc SHALL toggle AL_ON.
REQ-021 IDLE, alarm_in=1: set SHALL drive STOP_al high for LD_HOLD cycles, clear any snooze, and SHALL NOT change AL_ON.
REQ-022 STOP_al SHALL be asserted only from IDLE; a mode event during a STOP_al pulse SHALL be accepted, and the pulse SHALL complete.
REQ-023 mode_ind SHALL reflect the current state registered (no glitches).

Reset
REQ-024 While reset=0, the FSM SHALL be in IDLE, with hour=0 and min=0 (all BCD outputs 0).
REQ-025 While reset=0, LD_time, LD_alarm, STOP_al, AL_ON and buzz SHALL be 0, mode_ind SHALL be 00, and all counters and synchronizers SHALL be cleared.
REQ-026 Reset asserted mid-load SHALL terminate the load pulse immediately; deassertion SHALL be synchronized to clk.

Configuration
REQ-027 Macro CLOCK_SET_CTRL_SNOOZE_EN defined: in IDLE with alarm_in=1, inc SHALL start a snooze (AL_ON unchanged); buzz=0 for SNOOZE_S ticks, then buzz follows alarm_in; a repeated inc SHALL restart the count; the snooze SHALL clear when alarm_in falls.
REQ-028 Macro undefined: buzz = alarm_in & AL_ON, registered; inc in IDLE SHALL always toggle AL_ON; no snooze logic SHALL be present.

Verification
REQ-029 reset low mid-T_LOAD -> LD_time=0 immediately; after release: IDLE, outputs 0, mode_ind=00.
REQ-030 mode, inc x13, set, inc x60, set -> H_in1=1, H_in0=3, M_in1=0, M_in0=0 (minute wrapped 59->0); LD_time high exactly 16 cycles, mode_ind=11 during the pulse, then 00.
REQ-031 mode, mode, inc x7, set, inc x30, set -> LD_alarm high 16 cycles showing 07:30; LD_time stays 0.
REQ-032 mode, inc x2, then 10 tick_1s with no buttons -> IDLE, no load pulse; set and inc in the same cycle -> only set acted on.
REQ-033 AL_ON=1, alarm_in=1: set -> STOP_al high 16 cycles, AL_ON stays 1; with SNOOZE_EN: inc -> buzz=0 for 300 ticks, then 1.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven time/alarm setting controller for an alarm clock.
// Optional snooze feature: define CLOCK_SET_CTRL_SNOOZE_EN.
// Ports: clk, reset (async, active-low); btn_mode/btn_inc/btn_set raw buttons;
//   tick_1s 1 Hz pulse; alarm_in from the alarm clock;
//   H_in1/H_in0/M_in1/M_in0 BCD edit values; LD_time/LD_alarm/STOP_al/AL_ON
//   alarm clock controls; buzz buzzer drive; mode_ind 00 idle/01 time/10 alarm/11 load.
module clock_set_ctrl #(
    parameter int LD_HOLD   = 16,
    parameter int TIMEOUT_S = 10,
    parameter int SNOOZE_S  = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_set,
    input  logic       tick_1s,
    input  logic       alarm_in,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       STOP_al,
    output logic       AL_ON,
    output logic       buzz,
    output logic [1:0] mode_ind
);

    localparam int LW = $clog2(LD_HOLD + 1);
    localparam int TW = $clog2(TIMEOUT_S + 1);

    typedef enum logic [2:0] {
        IDLE, T_HOUR, T_MIN, T_LOAD, A_HOUR, A_MIN, A_LOAD
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    mode_nxt;
    logic [1:0]    rst_sync;
    logic          rst_n;
    logic [2:0]    s_mode, s_inc, s_set;
    logic          e_mode, e_inc, e_set;
    logic          ev_mode, ev_inc, ev_set, any_ev;
    logic          in_edit, in_load, ld_done, tmo_hit;
    logic          stop_req, al_toggle;
    logic [4:0]    hour;
    logic [5:0]    min;
    logic [LW-1:0] ld_cnt, stop_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [1:0]    h_t;
    logic [2:0]    m_t;

    // Reset asserts immediately, releases on a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // [0] meta flop, [1] synchronized level, [2] previous level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_mode <= '0;
            s_inc  <= '0;
            s_set  <= '0;
        end else begin
            s_mode <= {s_mode[1:0], btn_mode};
            s_inc  <= {s_inc[1:0], btn_inc};
            s_set  <= {s_set[1:0], btn_set};
        end
    end

    assign e_mode  = s_mode[1] & ~s_mode[2];
    assign e_inc   = s_inc[1] & ~s_inc[2];
    assign e_set   = s_set[1] & ~s_set[2];
    assign ev_set  = e_set;
    assign ev_mode = e_mode & ~e_set;
    assign ev_inc  = e_inc & ~e_set & ~e_mode;
    assign any_ev  = e_set | e_mode | e_inc;

    assign in_edit = (state == T_HOUR) || (state == T_MIN) ||
                     (state == A_HOUR) || (state == A_MIN);
    assign in_load = (state == T_LOAD) || (state == A_LOAD);
    assign ld_done = (ld_cnt == LW'(LD_HOLD - 1));
    assign tmo_hit = in_edit && !any_ev && tick_1s &&
                     (tmo_cnt == TW'(TIMEOUT_S - 1));
    assign stop_req = (state == IDLE) && ev_set && alarm_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (ev_mode) state_nxt = T_HOUR;
            T_HOUR: begin
                if (ev_set)       state_nxt = T_MIN;
                else if (ev_mode) state_nxt = A_HOUR;
                else if (tmo_hit) state_nxt = IDLE;
            end
            A_HOUR: begin
                if (ev_set)       state_nxt = A_MIN;
                else if (ev_mode) state_nxt = IDLE;
                else if (tmo_hit) state_nxt = IDLE;
            end
            T_MIN: begin
                if (ev_set)       state_nxt = T_LOAD;
                else if (ev_mode) state_nxt = IDLE;
                else if (tmo_hit) state_nxt = IDLE;
            end
            A_MIN: begin
                if (ev_set)       state_nxt = A_LOAD;
                else if (ev_mode) state_nxt = IDLE;
                else if (tmo_hit) state_nxt = IDLE;
            end
            T_LOAD: if (ld_done) state_nxt = IDLE;
            A_LOAD: if (ld_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mode_nxt = 2'b00;
        unique case (state_nxt)
            T_HOUR, T_MIN:  mode_nxt = 2'b01;
            A_HOUR, A_MIN:  mode_nxt = 2'b10;
            T_LOAD, A_LOAD: mode_nxt = 2'b11;
            default:        mode_nxt = 2'b00;
        endcase
    end

    // Indicators and load strobes registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_ind <= 2'b00;
            LD_time  <= 1'b0;
            LD_alarm <= 1'b0;
        end else begin
            mode_ind <= mode_nxt;
            LD_time  <= (state_nxt == T_LOAD);
            LD_alarm <= (state_nxt == A_LOAD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt  <= '0;
            tmo_cnt <= '0;
        end else begin
            if (in_load) ld_cnt <= ld_done ? '0 : ld_cnt + 1'b1;
            else         ld_cnt <= '0;
            if (!in_edit || any_ev || (state_nxt != state))
                tmo_cnt <= '0;
            else if (tick_1s)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hour <= '0;
            min  <= '0;
        end else if (ev_inc) begin
            if ((state == T_HOUR) || (state == A_HOUR))
                hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            if ((state == T_MIN) || (state == A_MIN))
                min <= (min == 6'd59) ? 6'd0 : min + 6'd1;
        end
    end

    // STOP_al runs on its own counter so a mode event can leave IDLE mid-pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_cnt <= '0;
            STOP_al  <= 1'b0;
        end else if (stop_req) begin
            stop_cnt <= LW'(LD_HOLD);
            STOP_al  <= 1'b1;
        end else begin
            if (stop_cnt != '0) stop_cnt <= stop_cnt - 1'b1;
            STOP_al <= (stop_cnt > LW'(1));
        end
    end

`ifdef CLOCK_SET_CTRL_SNOOZE_EN
    localparam int SW = $clog2(SNOOZE_S + 1);
    logic          snz_on;
    logic [SW-1:0] snz_cnt;

    assign al_toggle = !alarm_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snz_on  <= 1'b0;
            snz_cnt <= '0;
        end else if (!alarm_in || stop_req) begin
            snz_on  <= 1'b0;
            snz_cnt <= '0;
        end else if ((state == IDLE) && ev_inc) begin
            snz_on  <= 1'b1;
            snz_cnt <= '0;
        end else if (snz_on && tick_1s) begin
            if (snz_cnt == SW'(SNOOZE_S - 1)) begin
                snz_on  <= 1'b0;
                snz_cnt <= '0;
            end else begin
                snz_cnt <= snz_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) buzz <= 1'b0;
        else        buzz <= alarm_in & AL_ON & ~snz_on;
    end
`else
    assign al_toggle = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) buzz <= 1'b0;
        else        buzz <= alarm_in & AL_ON;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            AL_ON <= 1'b0;
        else if ((state == IDLE) && ev_inc && al_toggle)
            AL_ON <= ~AL_ON;
    end

    // Binary to BCD by range compare; units = value - 10*tens.
    always_comb begin
        h_t = 2'd0;
        if (hour >= 5'd20)      h_t = 2'd2;
        else if (hour >= 5'd10) h_t = 2'd1;
        m_t = 3'd0;
        if (min >= 6'd50)      m_t = 3'd5;
        else if (min >= 6'd40) m_t = 3'd4;
        else if (min >= 6'd30) m_t = 3'd3;
        else if (min >= 6'd20) m_t = 3'd2;
        else if (min >= 6'd10) m_t = 3'd1;
        H_in1 = h_t;
        H_in0 = 4'(hour - ({3'b000, h_t} * 5'd10));
        M_in1 = {1'b0, m_t};
        M_in0 = 4'(min - ({3'b000, m_t} * 6'd10));
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: scoreboard bench for clock_set_ctrl.
// Stimulus queues expected snapshots/pulses; a negedge monitor checks them.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_set = 1'b0;
    logic       tick_1s = 1'b0, alarm_in = 1'b0;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm, STOP_al, AL_ON, buzz;
    logic [1:0] mode_ind;

    clock_set_ctrl dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_set(btn_set),
        .tick_1s(tick_1s), .alarm_in(alarm_in),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al),
        .AL_ON(AL_ON), .buzz(buzz), .mode_ind(mode_ind)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [20:0] exp;
        logic [20:0] mask;
    } snap_t;

    typedef struct {
        int          which;
        logic [13:0] bcd;
        int          len;
    } pulse_t;

    snap_t  snap_q[$];
    pulse_t pulse_q[$];
    int     n_checks = 0;
    int     n_pass = 0;
    bit     busy = 0;
    bit     overlap = 0;

    localparam logic [20:0] ALL = 21'h1FFFFF;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [13:0] bcd(int hh, int mm);
        return {2'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
    endfunction

    function automatic logic [20:0] snap(int mi, int al, int bz, int lt,
                                         int la, int st, int hh, int mm);
        return {2'(mi), 1'(al), 1'(bz), 1'(lt), 1'(la), 1'(st), bcd(hh, mm)};
    endfunction

    task automatic push_snap(input string n, input logic [20:0] e,
                             input logic [20:0] m);
        snap_t s;
        s.name = n; s.exp = e; s.mask = m;
        snap_q.push_back(s);
    endtask

    task automatic push_pulse(input int w, input int hh, input int mm,
                              input int len);
        pulse_t p;
        p.which = w; p.bcd = bcd(hh, mm); p.len = len;
        pulse_q.push_back(p);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // bits: 1 mode, 2 inc, 4 set
    task automatic press(input int btns, input int n);
        for (int i = 0; i < n; i++) begin
            btn_mode = btns[0]; btn_inc = btns[1]; btn_set = btns[2];
            repeat (4) step();
            btn_mode = 0; btn_inc = 0; btn_set = 0;
            repeat (4) step();
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1s = 1; step();
            tick_1s = 0; step(); step();
        end
    endtask

    // Monitor: compares queued snapshots and measures load/stop pulses.
    initial begin
        logic [20:0] outv;
        logic [2:0]  cur, prev;
        pulse_t      pe;
        int          mw, len;
        bit          ind_bad;
        prev = '0; mw = 0; len = 0; ind_bad = 0;
        forever begin
            @(negedge clk);
            outv = {mode_ind, AL_ON, buzz, LD_time, LD_alarm, STOP_al,
                    H_in1, H_in0, M_in1, M_in0};
            while (snap_q.size() > 0) begin
                snap_t s;
                s = snap_q.pop_front();
                chk(s.name, 32'(outv & s.mask), 32'(s.exp & s.mask));
            end
            cur = {STOP_al, LD_alarm, LD_time};
            if (LD_time && LD_alarm) overlap = 1;
            if (busy) begin
                if (cur[mw]) begin
                    len++;
                    if (mw != 2 && mode_ind != 2'b11) ind_bad = 1;
                    if (len > 2000) begin
                        chk("pulse_len_bound", 32'(len), 32'(pe.len));
                        busy = 0;
                    end
                end else begin
                    chk("pulse_len", 32'(len), 32'(pe.len));
                    if (mw != 2) chk("mode_ind_11", 32'(ind_bad), 0);
                    busy = 0;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (cur[i] && !prev[i]) begin
                    if (busy) begin
                        chk("pulse_during_pulse", 32'(i + 1), 0);
                    end else if (pulse_q.size() == 0) begin
                        chk("unexpected_pulse", 32'(i + 1), 0);
                    end else begin
                        pe = pulse_q.pop_front();
                        chk("pulse_kind", 32'(i), 32'(pe.which));
                        chk("pulse_bcd", 32'(outv[13:0]), 32'(pe.bcd));
                        busy = 1; mw = i; len = 1;
                        ind_bad = (i != 2) && (mode_ind != 2'b11);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        bit seen;
        #2 reset = 0;
        repeat (3) step();
        push_snap("reset_state", snap(0, 0, 0, 0, 0, 0, 0, 0), ALL);
        reset = 1;
        repeat (5) step();

        // time edit 13:00 with minute wrap
        press(1, 1);
        push_snap("t_hour_entry", snap(1, 0, 0, 0, 0, 0, 0, 0), ALL);
        press(2, 13);
        push_snap("hour_13", snap(1, 0, 0, 0, 0, 0, 13, 0), ALL);
        press(4, 1);
        push_snap("t_min_entry", snap(1, 0, 0, 0, 0, 0, 13, 0), ALL);
        press(2, 59);
        push_snap("min_59", snap(1, 0, 0, 0, 0, 0, 13, 59), ALL);
        press(2, 1);
        push_snap("min_wrap", snap(1, 0, 0, 0, 0, 0, 13, 0), ALL);
        push_pulse(0, 13, 0, 16);
        press(4, 1);
        repeat (20) step();
        push_snap("after_ld_time", snap(0, 0, 0, 0, 0, 0, 13, 0), ALL);

        // reset in the middle of a time load
        press(1, 1);
        press(4, 1);
        push_pulse(0, 13, 0, 5);
        btn_set = 1;
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            seen = LD_time;
        end
        chk("ld_time_rose", 32'(seen), 1);
        repeat (5) @(posedge clk);
        #1 reset = 0;
        btn_set = 0;
        push_snap("reset_mid_load", snap(0, 0, 0, 0, 0, 0, 0, 0), ALL);
        repeat (3) step();
        reset = 1;
        repeat (6) step();
        push_snap("after_release", snap(0, 0, 0, 0, 0, 0, 0, 0), ALL);

        // alarm edit 07:30
        press(1, 2);
        push_snap("a_hour_entry", snap(2, 0, 0, 0, 0, 0, 0, 0), ALL);
        press(2, 7);
        press(4, 1);
        press(2, 30);
        push_snap("alarm_0730", snap(2, 0, 0, 0, 0, 0, 7, 30), ALL);
        push_pulse(1, 7, 30, 16);
        press(4, 1);
        repeat (20) step();
        push_snap("after_ld_alarm", snap(0, 0, 0, 0, 0, 0, 7, 30), ALL);

        // timeout after 10 ticks
        press(1, 1);
        press(2, 2);
        tick(9);
        push_snap("tick9_still_edit", snap(1, 0, 0, 0, 0, 0, 9, 30), ALL);
        tick(1);
        push_snap("timeout_idle", snap(0, 0, 0, 0, 0, 0, 9, 30), ALL);

        // set beats inc
        press(1, 1);
        press(6, 1);
        push_snap("set_over_inc", snap(1, 0, 0, 0, 0, 0, 9, 30), ALL);
        press(1, 1);
        push_snap("was_t_min", snap(0, 0, 0, 0, 0, 0, 9, 30), ALL);
        press(6, 1);
        push_snap("idle_set_inc", snap(0, 0, 0, 0, 0, 0, 9, 30), ALL);

        // AL_ON toggle, stop pulse
        press(2, 1);
        push_snap("al_on_toggle", snap(0, 1, 0, 0, 0, 0, 9, 30), ALL);
        alarm_in = 1;
        repeat (3) step();
        push_snap("buzz_on", snap(0, 1, 1, 0, 0, 0, 9, 30), ALL);
        push_pulse(2, 9, 30, 16);
        press(4, 1);
        repeat (20) step();
        push_snap("after_stop", snap(0, 1, 1, 0, 0, 0, 9, 30), ALL);
`ifdef CLOCK_SET_CTRL_SNOOZE_EN
        press(2, 1);
        push_snap("snooze_start", snap(0, 1, 0, 0, 0, 0, 9, 30), ALL);
        tick(299);
        push_snap("snooze_299", snap(0, 1, 0, 0, 0, 0, 9, 30), ALL);
        tick(1);
        push_snap("snooze_done", snap(0, 1, 1, 0, 0, 0, 9, 30), ALL);
`else
        press(2, 1);
        push_snap("al_off_alarm", snap(0, 0, 0, 0, 0, 0, 9, 30), ALL);
        press(2, 1);
        push_snap("al_on_alarm", snap(0, 1, 1, 0, 0, 0, 9, 30), ALL);
`endif

        // mode accepted during a stop pulse
        push_pulse(2, 9, 30, 16);
        btn_set = 1; repeat (4) step();
        btn_set = 0; repeat (2) step();
        btn_mode = 1; repeat (4) step();
        btn_mode = 0; repeat (4) step();
        push_snap("mode_in_stop", snap(1, 1, 1, 0, 0, 1, 9, 30), ALL);
        repeat (10) step();
        press(1, 2);
        push_snap("back_idle", snap(0, 1, 1, 0, 0, 0, 9, 30), ALL);

        // hour wrap 23 -> 0
        alarm_in = 0;
        repeat (2) step();
        press(1, 1);
        press(2, 14);
        push_snap("hour_23", snap(1, 1, 0, 0, 0, 0, 23, 30), ALL);
        press(2, 1);
        push_snap("hour_wrap", snap(1, 1, 0, 0, 0, 0, 0, 30), ALL);
        press(1, 2);
        push_snap("final_idle", snap(0, 1, 0, 0, 0, 0, 0, 30), ALL);

        for (int i = 0; i < 100 && (busy || snap_q.size() > 0); i++)
            step();
        repeat (2) step();
        chk("snap_q_drained", 32'(snap_q.size()), 0);
        chk("pulse_q_drained", 32'(pulse_q.size()), 0);
        chk("pulse_idle", 32'(busy), 0);
        chk("ld_never_both", 32'(overlap), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
